// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared constants, FSM encoding and address-wrap helper for the RAM stream reader
package onchip_mem_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 5120;
    localparam int CNT_W     = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // The RAM is not a power of two deep, so the address wraps explicitly at MEM_DEPTH.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - small synchronous FIFO holding framed stream words ahead of the sink
module stream_sync_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = store[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW + 1)'(DEPTH));

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// rtl/onchip_mem_stream_reader.sv - reads a block of on-chip RAM words and sources them as a framed stream
module onchip_mem_stream_reader
    import onchip_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = DATA_W + 2;
    localparam logic [PW+1:0] DEPTH_C = (PW + 2)'(FIFO_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic              first;
    logic              inflight;
    logic              cap_sop;
    logic              cap_eop;

    logic [FW-1:0]     head;
    logic [PW:0]       fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PW+1:0]     credit;
    logic              issue;
    logic              pop;
    logic              drain_done;

    // A read is only issued when its returning word is guaranteed a FIFO slot.
    assign credit = {1'b0, fifo_count} + {{(PW + 1){1'b0}}, inflight};
    assign issue  = (state == S_RUN) && (credit < DEPTH_C) && !fifo_full;
    assign pop    = !fifo_empty && src_ready;

    // Look one pop ahead so done lands the cycle right after the last beat is taken.
    assign drain_done = !inflight &&
                        (fifo_empty || ((fifo_count == (PW + 1)'(1)) && pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            first     <= 1'b0;
            inflight  <= 1'b0;
            cap_sop   <= 1'b0;
            cap_eop   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                cap_sop   <= first;
                cap_eop   <= (remaining == CNT_W'(1));
                addr      <= next_addr(addr);
                remaining <= remaining - 1'b1;
                first     <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        first     <= 1'b1;
                        // An empty transfer still passes through DRAIN so busy spans two cycles.
                        state     <= (word_count == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN:   if (issue && (remaining == CNT_W'(1))) state <= S_DRAIN;
                S_DRAIN: if (drain_done) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    stream_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({mem_readdata, cap_sop, cap_eop}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign mem_chipselect = issue;
    assign mem_address    = issue ? addr : '0;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign src_valid = !fifo_empty;
    assign src_data  = fifo_empty ? '0 : head[FW-1:2];
    assign src_sop   = !fifo_empty && head[1];
    assign src_eop   = !fifo_empty && head[0];

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb/tb_onchip_mem_stream_reader.sv - self-checking bench for the RAM stream reader
module tb_onchip_mem_stream_reader;
    import onchip_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready = 1'b1;
    logic              src_sop;
    logic              src_eop;

    onchip_mem_stream_reader #(.FIFO_DEPTH(4)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_sop        (src_sop),
        .src_eop        (src_eop)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

    int checks = 0;
    int errors = 0;

    logic [DATA_W+1:0] beat_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int cyc = 0, cs_cnt, valid_cnt, busy_cnt, done_cnt, done_cyc, start_cyc;
    int first_beat_cyc, last_beat_cyc, stall_viol, max_fc;
    logic              prev_stall = 1'b0;
    logic [DATA_W+1:0] prev_head;

    int ready_mode = 0;
    int rcnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                0: src_ready = 1'b1;
                1: src_ready = (rcnt % 20 >= 5 && rcnt % 20 < 11) ? 1'b0 : rcnt[0];
                2: src_ready = 1'($urandom_range(0, 1));
                default: src_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_chipselect) begin
                addr_q.push_back(mem_address);
                cs_cnt++;
            end
            if (src_valid) valid_cnt++;
            if (src_valid && src_ready) begin
                if (beat_q.size() == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beat_q.push_back({src_data, src_sop, src_eop});
            end
            if (prev_stall && (!src_valid || {src_data, src_sop, src_eop} !== prev_head))
                stall_viol++;
            prev_stall = src_valid && !src_ready;
            prev_head  = {src_data, src_sop, src_eop};
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (start && !busy) start_cyc = cyc;
            if (int'(u_dut.u_fifo.count) > max_fc) max_fc = int'(u_dut.u_fifo.count);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        beat_q.delete();
        addr_q.delete();
        cs_cnt = 0; valid_cnt = 0; busy_cnt = 0; done_cnt = 0;
        done_cyc = -1; start_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
        stall_viol = 0; max_fc = 0;
    endtask

    task automatic pulse_start(input int b, input int c);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = ADDR_W'(b);
        word_count = CNT_W'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input int b, input int c, input bit mid_start);
        int n;
        clear_mon();
        pulse_start(b, c);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            pulse_start(999, 5);
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (10) @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_xfer(input string tag, input int b, input int c);
        int bad_addr;
        chk({tag, "_beats"}, 64'(beat_q.size()), 64'(c));
        chk({tag, "_cs_cycles"}, 64'(cs_cnt), 64'(c));
        for (int i = 0; i < c && i < beat_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]),
                64'({mem[(b + i) % MEM_DEPTH], i == 0, i == c - 1}));
        end
        bad_addr = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (i >= c || int'(addr_q[i]) != (b + i) % MEM_DEPTH) bad_addr++;
        chk({tag, "_addr_seq_bad"}, 64'(bad_addr), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_stall_stable_viol"}, 64'(stall_viol), 64'd0);
        chk({tag, "_fifo_le_depth"}, 64'(max_fc <= 4), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cs"}, 64'(mem_chipselect), 64'd0);
        chk({tag, "_addr"}, 64'(mem_address), 64'd0);
        chk({tag, "_valid"}, 64'(src_valid), 64'd0);
        chk({tag, "_sop"}, 64'(src_sop), 64'd0);
        chk({tag, "_eop"}, 64'(src_eop), 64'd0);
        chk({tag, "_data"}, 64'(src_data), 64'd0);
        chk({tag, "_consts"}, 64'({mem_write, mem_byteenable, mem_clken}), 64'h1F);
    endtask

    initial begin
        int b, c;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: full-rate transfer
        ready_mode = 0;
        run(0, 8, 1'b0);
        check_xfer("t1", 0, 8);
        chk("t1_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 64'd7);
        chk("t1_done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);

        // T2: address wrap at the top of the RAM
        run(5118, 4, 1'b0);
        check_xfer("t2", 5118, 4);

        // T3: toggling ready with a long stall burst
        ready_mode = 1;
        run(100, 8, 1'b0);
        check_xfer("t3", 100, 8);

        // T4: zero-length and single-word transfers
        ready_mode = 0;
        run(7, 0, 1'b0);
        chk("t4_done_delay", 64'(done_cyc - start_cyc), 64'd2);
        chk("t4_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("t4_cs_cycles", 64'(cs_cnt), 64'd0);
        chk("t4_valid_cycles", 64'(valid_cnt), 64'd0);
        chk("t4_done_pulses", 64'(done_cnt), 64'd1);
        run(42, 1, 1'b0);
        check_xfer("t4_one", 42, 1);

        // T5: a second start while running is ignored
        run(2000, 12, 1'b1);
        check_xfer("t5", 2000, 12);

        // Randomized transfers under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            b = (k % 2 == 0) ? int'($urandom_range(0, MEM_DEPTH - 1))
                             : int'($urandom_range(MEM_DEPTH - 10, MEM_DEPTH - 1));
            c = int'($urandom_range(1, 24));
            run(b, c, 1'b0);
            check_xfer($sformatf("rnd%0d", k), b, c);
        end

        // T6: reset while draining with data waiting at the sink
        ready_mode = 3;
        clear_mon();
        pulse_start(200, 3);
        repeat (10) @(negedge clk);
        chk("t6_valid_before_reset", 64'(src_valid), 64'd1);
        chk("t6_busy_before_reset", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        reset_n = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        run(300, 6, 1'b0);
        check_xfer("t6_after", 300, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
